csa_pipe: RTL and testbench

Parametrised, pipelined carry-skip adder/subtractor with a valid/ready stream interface. Operand width, skip-block size and pipeline depth are generics. Carries ripple inside each block, and a per-block skip mux bypasses the ripple when all propagate bits are set. The block is the drop-in arithmetic datapath for pipelined units that need add, subtract, carry-out and signed overflow at full throughput with backpressure.

---
 rtl/csa_pipe_if.sv | 28 ++
 rtl/csa_pipe.sv | 185 ++++++++++++++++++
 tb/tb_csa_pipe.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/csa_pipe_if.sv
// rtl/csa_pipe_if.sv - valid/ready stream bundle for the csa_pipe adder datapath
interface csa_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Arithmetic datapath side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csa_pipe.sv
// rtl/csa_pipe.sv - pipelined carry-skip adder/subtractor with valid/ready flow control
// Optional feature: define CSA_PIPE_SAT_EN to clamp the sum to the signed limit on overflow.
module csa_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  csa_pipe_if.slave io
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;
  localparam int SB   = BPS * BLOCK;

  logic [WIDTH-1:0]  bx;
  logic [WIDTH-1:0]  p0;
  logic [WIDTH-1:0]  g0;
  logic              c0;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  res_d;
  logic [WIDTH-1:0]  res_q;
  logic              cout_d;
  logic              cout_q;
  logic              ovf_d;
  logic              ovf_q;

  // Operand conditioning: subtraction is a + ~b + 1, cin is ignored then.
  always_comb begin
    bx = io.sub ? ~io.b : io.b;
    c0 = io.sub ? 1'b1 : io.cin;
    p0 = io.a ^ bx;
    g0 = io.a & bx;
  end

  // Advance chain, evaluated from the output backwards so bubbles collapse.
  always_comb begin : adv_chain
    logic go;
    adv = '0;
    go  = !valid_q[STAGES-1] || io.out_ready;
    adv[STAGES-1] = go;
    for (int j = STAGES - 2; j >= 0; j--) begin
      go     = !valid_q[j] || go;
      adv[j] = go;
    end
  end

  // Valid bits move one stage forward wherever that stage advances.
  always_comb begin
    valid_d = valid_q;
    if (adv[0]) valid_d[0] = io.in_valid;
    for (int j = 1; j < STAGES; j++) begin
      if (adv[j]) valid_d[j] = valid_q[j-1];
    end
  end

  // Stage valid register; reset flushes everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  assign io.in_ready  = adv[0];
  assign io.out_valid = valid_q[STAGES-1];
  assign io.sum       = res_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;

  for (genvar s = 0; s < STAGES; s++) begin : stg
    // Remaining p/g bits, starting at this stage's slice, and the carry into it.
    logic [WIDTH-s*SB-1:0] pin_all;
    logic [WIDTH-s*SB-1:0] gin_all;
    logic                  ci;
    logic                  vin;
    logic [SB-1:0]         so;
    logic                  co;
    logic [(s+1)*SB-1:0]   acc;

    if (s == 0) begin : src_in
      assign pin_all = p0;
      assign gin_all = g0;
      assign ci      = c0;
      assign vin     = io.in_valid;
      assign acc     = so;
    end else begin : src_reg
      assign pin_all = stg[s-1].mid.p_q;
      assign gin_all = stg[s-1].mid.g_q;
      assign ci      = stg[s-1].mid.c_q;
      assign vin     = valid_q[s-1];
      assign acc     = {so, stg[s-1].mid.s_q};
    end

    // Ripple inside each block; the skip mux forwards the block carry-in when all p are set.
    always_comb begin : ripple
      logic c;
      logic bc;
      logic allp;
      c    = ci;
      bc   = 1'b0;
      allp = 1'b0;
      so   = '0;
      for (int k = 0; k < BPS; k++) begin
        bc   = c;
        allp = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
          so[k*BLOCK+i] = pin_all[k*BLOCK+i] ^ c;
          allp          = allp & pin_all[k*BLOCK+i];
          c             = gin_all[k*BLOCK+i] | (pin_all[k*BLOCK+i] & c);
        end
        c = allp ? bc : c;
      end
      co = c;
    end

    if (s < STAGES - 1) begin : mid
      localparam int REM = WIDTH - (s + 1) * SB;
      logic [REM-1:0]      p_d;
      logic [REM-1:0]      p_q;
      logic [REM-1:0]      g_d;
      logic [REM-1:0]      g_q;
      logic [(s+1)*SB-1:0] s_d;
      logic [(s+1)*SB-1:0] s_q;
      logic                c_d;
      logic                c_q;

      // Capture finished sum bits, pending p/g bits and the inter-block carry.
      always_comb begin
        p_d = p_q;
        g_d = g_q;
        s_d = s_q;
        c_d = c_q;
        if (adv[s] && vin) begin
          p_d = pin_all[WIDTH-s*SB-1:SB];
          g_d = gin_all[WIDTH-s*SB-1:SB];
          s_d = acc;
          c_d = co;
        end
      end

      // Payload register; contents are qualified by the stage valid bit, so no reset.
      always_ff @(posedge clk) begin
        p_q <= p_d;
        g_q <= g_d;
        s_q <= s_d;
        c_q <= c_d;
      end
    end else begin : fin
      logic ovf_raw;
      // Carry into the MSB equals sum[MSB] ^ p[MSB], so overflow needs no extra carry tap.
      assign ovf_raw = co ^ acc[WIDTH-1] ^ pin_all[SB-1];

      // Final result; held while the consumer stalls.
      always_comb begin
        res_d  = res_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (adv[s] && vin) begin
`ifdef CSA_PIPE_SAT_EN
          // A wrapped MSB of 1 means positive overflow, so clamp to the opposite extreme.
          res_d = ovf_raw ? {~acc[WIDTH-1], {(WIDTH-1){acc[WIDTH-1]}}} : acc;
`else
          res_d = acc;
`endif
          cout_d = co;
          ovf_d  = ovf_raw;
        end
      end
    end
  end

  // Output register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      res_q  <= res_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end
endmodule

// File: tb/tb_csa_pipe.sv
// tb/tb_csa_pipe.sv - directed-vector self-checking bench for csa_pipe
module tb_csa_pipe;
`ifdef CSA_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csa_pipe_if #(.WIDTH(32)) m ();
  csa_pipe_if #(.WIDTH(32)) m1 ();
  csa_pipe_if #(.WIDTH(32)) m8 ();

  csa_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut  (.clk(clk), .rst_n(rst_n), .io(m.slave));
  csa_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(m1.slave));
  csa_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(m8.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [32:0] t;
    logic [31:0] bb;
    logic [31:0] s;
    logic        c;
    logic        ov;
    bb = sb ? ~b : b;
    c  = sb ? 1'b1 : ci;
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, c};
    ov = (a[31] == bb[31]) && (t[31] != a[31]);
    s  = t[31:0];
    if (SAT && ov) s = a[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    return {ov, t[32], s};
  endfunction

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb,
                       input logic [31:0] e_sum, input logic e_co, input logic e_ov);
    int lat;
    check_eq({tag, ".rdy"}, m.in_ready, 1);
    m.a = a; m.b = b; m.cin = ci; m.sub = sb;
    m.in_valid = 1'b1; m.out_ready = 1'b1;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    lat = 1;
    while (!m.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, ".lat"}, lat, 2);
    check_eq({tag, ".sum"}, m.sum, e_sum);
    check_eq({tag, ".cout"}, m.cout, e_co);
    check_eq({tag, ".ovf"}, m.ovf, e_ov);
  endtask

  logic [31:0] va [8];
  logic [31:0] vb [8];
  logic        vc [8];
  logic        vs [8];
  logic [33:0] ve [8];
  logic [33:0] held;
  logic [33:0] r1, r8;
  logic        acc_now, g1, g8;
  int          nin, nout, stale, l1, l8, t;

  initial begin
    m.in_valid = 0;  m.a = 0;  m.b = 0;  m.cin = 0;  m.sub = 0;  m.out_ready = 1;
    m1.in_valid = 0; m1.a = 0; m1.b = 0; m1.cin = 0; m1.sub = 0; m1.out_ready = 1;
    m8.in_valid = 0; m8.a = 0; m8.b = 0; m8.cin = 0; m8.sub = 0; m8.out_ready = 1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset.out_valid", m.out_valid, 0);
    check_eq("reset.sum", m.sum, 0);
    check_eq("reset.cout", m.cout, 0);
    check_eq("reset.ovf", m.ovf, 0);
    check_eq("reset.in_ready", m.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("inc_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("pos_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
          SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1);
    do_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
          SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1);
    do_op("skip_all", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("cin_add",  32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0);
    do_op("sub_zero", 32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

    // All-skip chain through the 1-stage and 8-stage builds.
    check_eq("skip1.rdy", m1.in_ready, 1);
    check_eq("skip8.rdy", m8.in_ready, 1);
    m1.a = 32'hAAAA_AAAA; m1.b = 32'h5555_5555; m1.cin = 1'b1; m1.in_valid = 1'b1;
    m8.a = 32'hAAAA_AAAA; m8.b = 32'h5555_5555; m8.cin = 1'b1; m8.in_valid = 1'b1;
    @(posedge clk); #1;
    m1.in_valid = 1'b0; m8.in_valid = 1'b0;
    g1 = 0; g8 = 0; l1 = 0; l8 = 0; r1 = '0; r8 = '0; t = 1;
    while (t <= 20 && !(g1 && g8)) begin
      if (!g1 && m1.out_valid) begin g1 = 1; l1 = t; r1 = {m1.ovf, m1.cout, m1.sum}; end
      if (!g8 && m8.out_valid) begin g8 = 1; l8 = t; r8 = {m8.ovf, m8.cout, m8.sum}; end
      @(posedge clk); #1;
      t++;
    end
    check_eq("skip1.lat", l1, 1);
    check_eq("skip1.res", r1, 34'h1_0000_0000);
    check_eq("skip8.lat", l8, 8);
    check_eq("skip8.res", r8, 34'h1_0000_0000);

    // Backpressure: 8 back-to-back transactions, consumer stalls cycles 3..5.
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom;
      vc[i] = 1'($urandom_range(0, 1)); vs[i] = 1'($urandom_range(0, 1));
      ve[i] = model(va[i], vb[i], vc[i], vs[i]);
    end
    nin = 0; nout = 0; held = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
      m.out_ready = !(cyc >= 3 && cyc <= 5);
      m.in_valid  = (nin < 8);
      if (nin < 8) begin
        m.a = va[nin]; m.b = vb[nin]; m.cin = vc[nin]; m.sub = vs[nin];
      end
      @(negedge clk);
      if (!m.out_ready) begin
        check_eq("bp.in_ready", m.in_ready, 0);
        check_eq("bp.hold_valid", m.out_valid, 1);
        if (cyc == 3) held = {m.ovf, m.cout, m.sum};
        else check_eq("bp.hold_data", {m.ovf, m.cout, m.sum}, held);
      end
      if (m.out_valid && m.out_ready) begin
        check_eq($sformatf("bp.res%0d", nout), {m.ovf, m.cout, m.sum}, ve[nout]);
        nout++;
      end
      acc_now = m.in_valid && m.in_ready;
      @(posedge clk); #1;
      if (acc_now) nin++;
    end
    m.in_valid = 1'b0;
    check_eq("bp.count", nout, 8);

    // Reset with two transactions in flight.
    @(posedge clk); #1;
    m.out_ready = 1'b0; m.in_valid = 1'b1;
    m.a = 32'd1; m.b = 32'd2; m.cin = 1'b0; m.sub = 1'b0;
    @(posedge clk); #1;
    m.a = 32'd3; m.b = 32'd4;
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    check_eq("rst.pre_valid", m.out_valid, 1);
    check_eq("rst.pre_sum", m.sum, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst.out_valid", m.out_valid, 0);
    check_eq("rst.sum", m.sum, 0);
    check_eq("rst.cout", m.cout, 0);
    check_eq("rst.ovf", m.ovf, 0);
    check_eq("rst.in_ready", m.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    m.out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m.out_valid) stale++;
    end
    check_eq("rst.stale", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
